// File: rtl/playback_ctrl_pkg.sv
// Shared types and default constants for the playback controller.
package playback_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SONG_REQ = 2'd1,
    ST_VOL_REQ  = 2'd2
  } state_e;

  // Direction of a pending song change.
  typedef enum logic {
    SONG_FWD  = 1'b0,
    SONG_BACK = 1'b1
  } song_dir_e;

  // Direction of a pending volume change (UP = louder = lower attenuation).
  typedef enum logic {
    VOL_UP   = 1'b0,
    VOL_DOWN = 1'b1
  } vol_dir_e;

  localparam int          DEF_SONG_NUM    = 4;
  localparam int          DEF_MAX_LEVEL   = 8;
  localparam int          DEF_INIT_LEVEL  = 4;
  localparam logic [7:0]  DEF_ATT_STEP    = 8'h10;
  localparam int          DEF_ACK_TIMEOUT = 2000;

  localparam int SONG_W  = 3;
  localparam int LEVEL_W = 4;

  // SCI_VOL word: same attenuation on left and right byte, truncated to 8 bits.
  function automatic logic [15:0] vol_word(input logic [LEVEL_W-1:0] level,
                                           input logic [7:0]         step);
    logic [7:0] att;
    att = 8'({4'd0, level} * step);
    return {att, att};
  endfunction

endpackage

// File: rtl/playback_ctrl_if.sv
// Request/acknowledge link between the playback controller and the mp3 driver.
//
// Handshake: the controller raises a req together with a stable payload
// (o_song_select or o_vol) and holds both until it samples the matching ack
// high at a rising edge, or until it gives up after the ack timeout. The req
// drops on that edge. The driver may hold ack high for one or more cycles;
// an ack seen while no matching req is up is ignored.
interface playback_ctrl_if;
  import playback_ctrl_pkg::*;

  logic [SONG_W-1:0] o_song_select;
  logic              o_song_req;
  logic              i_song_ack;
  logic [15:0]       o_vol;
  logic              o_vol_req;
  logic              i_vol_ack;

  // Controller side.
  modport master (
    output o_song_select, o_song_req, o_vol, o_vol_req,
    input  i_song_ack, i_vol_ack
  );

  // mp3 driver side.
  modport slave (
    input  o_song_select, o_song_req, o_vol, o_vol_req,
    output i_song_ack, i_vol_ack
  );
endinterface

// File: rtl/playback_ctrl_evt_latch.sv
// Holds one pending song change and one pending volume change. New events
// overwrite the entry (latest wins); a service clear in the same cycle as a
// new event loses to the event, since the event is newer than the one serviced.
module ctrl_evt_latch
  import playback_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_next,
  input  logic      i_pre,
  input  logic      i_finish_song,
  input  logic      i_vol_plus,
  input  logic      i_vol_dec,
  input  logic      i_clr_song,
  input  logic      i_clr_vol,
  output logic      o_song_pend,
  output song_dir_e o_song_dir,
  output logic      o_vol_pend,
  output vol_dir_e  o_vol_dir
);

  logic      song_pend_q;
  song_dir_e song_dir_q;
  logic      vol_pend_q;
  vol_dir_e  vol_dir_q;

  // Song entry: end-of-song and next both move forward and beat previous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      song_pend_q <= 1'b0;
      song_dir_q  <= SONG_FWD;
    end else if (i_finish_song || i_next) begin
      song_pend_q <= 1'b1;
      song_dir_q  <= SONG_FWD;
    end else if (i_pre) begin
      song_pend_q <= 1'b1;
      song_dir_q  <= SONG_BACK;
    end else if (i_clr_song) begin
      song_pend_q <= 1'b0;
    end
  end

  // Volume entry: simultaneous up and down cancel and leave the entry alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vol_pend_q <= 1'b0;
      vol_dir_q  <= VOL_UP;
    end else if (i_vol_plus ^ i_vol_dec) begin
      vol_pend_q <= 1'b1;
      vol_dir_q  <= i_vol_plus ? VOL_UP : VOL_DOWN;
    end else if (i_clr_vol) begin
      vol_pend_q <= 1'b0;
    end
  end

  assign o_song_pend = song_pend_q;
  assign o_song_dir  = song_dir_q;
  assign o_vol_pend  = vol_pend_q;
  assign o_vol_dir   = vol_dir_q;

endmodule

// File: rtl/playback_ctrl.sv
// Playback controller: turns command pulses into song-select and SCI volume
// updates, each delivered to the mp3 driver over req/ack with an ack timeout.
module playback_ctrl
  import playback_ctrl_pkg::*;
#(
  parameter int         SONG_NUM    = DEF_SONG_NUM,
  parameter int         MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int         INIT_LEVEL  = DEF_INIT_LEVEL,
  parameter logic [7:0] ATT_STEP    = DEF_ATT_STEP,
  parameter int         ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_next,
  input  logic               i_pre,
  input  logic               i_vol_plus,
  input  logic               i_vol_dec,
  input  logic               i_pause,
  input  logic               i_finish_song,
  playback_ctrl_if.master    mp3,
  output logic [LEVEL_W-1:0] o_vol_level,
  output logic               o_pause,
  output logic               o_busy,
  output logic               o_timeout,
  output state_e             o_state_dbg
);

  localparam int                 CNT_W      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [SONG_W-1:0]  SONG_LAST  = SONG_W'(SONG_NUM - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_INIT = LEVEL_W'(INIT_LEVEL);

  state_e              state_q;
  logic [SONG_W-1:0]   song_sel_q;
  logic                song_req_q;
  logic [LEVEL_W-1:0]  level_q;
  logic [15:0]         vol_q;
  logic                vol_req_q;
  logic                timeout_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                pause_q;
  logic                pause_d;

  logic                song_pend;
  song_dir_e           song_dir;
  logic                vol_pend;
  vol_dir_e            vol_dir;
  logic                issue_song;
  logic                issue_vol;
  logic [SONG_W-1:0]   song_nxt;
  logic [LEVEL_W-1:0]  level_nxt;

  // Song has priority over volume when both are waiting in IDLE.
  assign issue_song = (state_q == ST_IDLE) && song_pend;
  assign issue_vol  = (state_q == ST_IDLE) && !song_pend && vol_pend;

  ctrl_evt_latch u_evt_latch (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_next        (i_next),
    .i_pre         (i_pre),
    .i_finish_song (i_finish_song),
    .i_vol_plus    (i_vol_plus),
    .i_vol_dec     (i_vol_dec),
    .i_clr_song    (issue_song),
    .i_clr_vol     (issue_vol),
    .o_song_pend   (song_pend),
    .o_song_dir    (song_dir),
    .o_vol_pend    (vol_pend),
    .o_vol_dir     (vol_dir)
  );

  // Next song index (wrapping) and next attenuation level (saturating).
  always_comb begin
    song_nxt  = song_sel_q;
    level_nxt = level_q;
    if (song_dir == SONG_FWD) begin
      song_nxt = (song_sel_q == SONG_LAST) ? '0 : song_sel_q + 1'b1;
    end else begin
      song_nxt = (song_sel_q == '0) ? SONG_LAST : song_sel_q - 1'b1;
    end
    if (vol_dir == VOL_UP) begin
      level_nxt = (level_q == '0) ? '0 : level_q - 1'b1;
    end else begin
      level_nxt = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 1'b1;
    end
  end

  // Pause toggles directly; starting a song change always un-pauses.
  always_comb begin
    pause_d = pause_q;
    if (issue_song) begin
      pause_d = 1'b0;
    end else if (i_pause) begin
      pause_d = ~pause_q;
    end
  end

  // Pause state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= pause_d;
    end
  end

  // Request sequencer with registered payloads, reqs and timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      song_sel_q <= '0;
      song_req_q <= 1'b0;
      level_q    <= LEVEL_INIT;
      vol_q      <= vol_word(LEVEL_INIT, ATT_STEP);
      vol_req_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue_song) begin
            song_sel_q <= song_nxt;
            song_req_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_SONG_REQ;
          end else if (issue_vol) begin
            level_q    <= level_nxt;
            vol_q      <= vol_word(level_nxt, ATT_STEP);
            vol_req_q  <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_VOL_REQ;
          end
        end
        ST_SONG_REQ: begin
          if (mp3.i_song_ack) begin
            song_req_q <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            song_req_q <= 1'b0;
            timeout_q  <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_VOL_REQ: begin
          if (mp3.i_vol_ack) begin
            vol_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            vol_req_q <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          song_req_q <= 1'b0;
          vol_req_q  <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign mp3.o_song_select = song_sel_q;
  assign mp3.o_song_req    = song_req_q;
  assign mp3.o_vol         = vol_q;
  assign mp3.o_vol_req     = vol_req_q;
  assign o_vol_level       = level_q;
  assign o_pause           = pause_q;
  assign o_busy            = (state_q != ST_IDLE);
  assign o_timeout         = timeout_q;
  assign o_state_dbg       = state_q;

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed bench for playback_ctrl: song/volume sequencing, priority,
// saturation, pause interaction, ack timeout and mid-handshake reset.
module tb_playback_ctrl;
  import playback_ctrl_pkg::*;

  localparam logic [5:0] M_FIN   = 6'b100000;
  localparam logic [5:0] M_PRE   = 6'b010000;
  localparam logic [5:0] M_NEXT  = 6'b001000;
  localparam logic [5:0] M_PLUS  = 6'b000100;
  localparam logic [5:0] M_DEC   = 6'b000010;
  localparam logic [5:0] M_PAUSE = 6'b000001;

  logic       clk;
  logic       rst_n;
  logic       i_next, i_pre, i_vol_plus, i_vol_dec, i_pause, i_finish_song;
  logic [3:0] o_vol_level;
  logic       o_pause, o_busy, o_timeout;
  state_e     o_state_dbg;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  playback_ctrl_if sif ();

  playback_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_next        (i_next),
    .i_pre         (i_pre),
    .i_vol_plus    (i_vol_plus),
    .i_vol_dec     (i_vol_dec),
    .i_pause       (i_pause),
    .i_finish_song (i_finish_song),
    .mp3           (sif.master),
    .o_vol_level   (o_vol_level),
    .o_pause       (o_pause),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout),
    .o_state_dbg   (o_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [5:0] m);
    {i_finish_song, i_pre, i_next, i_vol_plus, i_vol_dec, i_pause} = m;
    tick();
    {i_finish_song, i_pre, i_next, i_vol_plus, i_vol_dec, i_pause} = 6'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sel"},     32'(sif.o_song_select), 32'd0);
    check({tag, "_level"},   32'(o_vol_level),       32'd4);
    check({tag, "_vol"},     32'(sif.o_vol),         32'h4040);
    check({tag, "_pause"},   32'(o_pause),           32'd0);
    check({tag, "_sreq"},    32'(sif.o_song_req),    32'd0);
    check({tag, "_vreq"},    32'(sif.o_vol_req),     32'd0);
    check({tag, "_busy"},    32'(o_busy),            32'd0);
    check({tag, "_timeout"}, 32'(o_timeout),         32'd0);
    check({tag, "_state"},   32'(o_state_dbg),       32'(ST_IDLE));
  endtask

  // Wait (bounded) for a req to rise.
  task automatic wait_req(input bit is_vol, input string tag);
    int n;
    n = 0;
    while (!(is_vol ? sif.o_vol_req : sif.o_song_req) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(is_vol ? sif.o_vol_req : sif.o_song_req), 32'd1);
  endtask

  // Compare current song select against the next scoreboard entry.
  task automatic sb_song(input string tag);
    logic [31:0] e;
    check({tag, "_sbq"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_sel"}, 32'(sif.o_song_select), e);
    end
  endtask

  // Hold off the ack for 'hold' cycles with req high, then ack for one cycle.
  task automatic ack_req(input bit is_vol, input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold"}, 32'(is_vol ? sif.o_vol_req : sif.o_song_req), 32'd1);
      tick();
    end
    check({tag, "_pre_ack"}, 32'(is_vol ? sif.o_vol_req : sif.o_song_req), 32'd1);
    if (is_vol) sif.i_vol_ack = 1'b1; else sif.i_song_ack = 1'b1;
    tick();
    sif.i_vol_ack  = 1'b0;
    sif.i_song_ack = 1'b0;
    check({tag, "_drop"}, 32'(is_vol ? sif.o_vol_req : sif.o_song_req), 32'd0);
    check({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  logic [3:0]  lvl_tab [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
  logic [15:0] vol_tab [5] = '{16'h3030, 16'h2020, 16'h1010, 16'h0000, 16'h0000};

  initial begin
    int cnt;
    rst_n = 1'b0;
    {i_finish_song, i_pre, i_next, i_vol_plus, i_vol_dec, i_pause} = 6'b0;
    sif.i_song_ack = 1'b0;
    sif.i_vol_ack  = 1'b0;
    do_reset();
    check_reset("rst");

    // T1: next, ack 3 cycles after req -> req high 4 cycles
    pulse(M_NEXT);
    check("t1_lat", 32'(sif.o_song_req), 32'd0);
    tick();
    exp_q.push_back(32'd1);
    check("t1_req", 32'(sif.o_song_req), 32'd1);
    sb_song("t1");
    check("t1_pause", 32'(o_pause), 32'd0);
    ack_req(1'b0, 3, "t1");

    // T2: previous to 0, previous wraps to 3, then next x4 while busy
    exp_q.push_back(32'd0);
    pulse(M_PRE);
    wait_req(1'b0, "t2a");
    sb_song("t2a");
    ack_req(1'b0, 1, "t2a");
    exp_q.push_back(32'd3);
    pulse(M_PRE);
    wait_req(1'b0, "t2b");
    sb_song("t2b");
    ack_req(1'b0, 0, "t2b");
    exp_q.push_back(32'd0);
    pulse(M_NEXT);
    wait_req(1'b0, "t2c");
    sb_song("t2c");
    for (int i = 0; i < 4; i++) pulse(M_NEXT);
    ack_req(1'b0, 0, "t2c");
    exp_q.push_back(32'd1);
    wait_req(1'b0, "t2d");
    sb_song("t2d");
    ack_req(1'b0, 0, "t2d");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_no_more", 32'(sif.o_song_req), 32'd0);
    end
    check("t2_final_sel", 32'(sif.o_song_select), 32'd1);

    // T3: louder x5 from reset saturates at 0; simultaneous up/down cancels
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(M_PLUS);
      wait_req(1'b1, "t3");
      check("t3_level", 32'(o_vol_level), 32'(lvl_tab[i]));
      check("t3_vol",   32'(sif.o_vol),   32'(vol_tab[i]));
      ack_req(1'b1, 1, "t3");
    end
    pulse(M_PLUS | M_DEC);
    for (int i = 0; i < 5; i++) begin
      check("t3_cancel_vreq", 32'(sif.o_vol_req), 32'd0);
      check("t3_cancel_busy", 32'(o_busy), 32'd0);
      tick();
    end

    // T4: paused, finish+pre same cycle -> +1 and unpause; vol waits for song
    pulse(M_PAUSE);
    check("t4_paused", 32'(o_pause), 32'd1);
    pulse(M_FIN | M_PRE);
    pulse(M_DEC);
    wait_req(1'b0, "t4s");
    exp_q.push_back(32'd1);
    sb_song("t4s");
    check("t4_unpause", 32'(o_pause), 32'd0);
    check("t4_vreq_wait", 32'(sif.o_vol_req), 32'd0);
    ack_req(1'b0, 2, "t4s");
    check("t4_gap", 32'(sif.o_vol_req), 32'd0);
    wait_req(1'b1, "t4v");
    check("t4_level", 32'(o_vol_level), 32'd1);
    check("t4_vol",   32'(sif.o_vol),   32'h1010);
    ack_req(1'b1, 0, "t4v");

    // T5: no ack -> req high ACK_TIMEOUT cycles, one-cycle timeout pulse
    do_reset();
    pulse(M_NEXT);
    wait_req(1'b0, "t5");
    exp_q.push_back(32'd1);
    sb_song("t5");
    check("t5_to_idle", 32'(o_timeout), 32'd0);
    cnt = 0;
    while (sif.o_song_req && cnt < 2100) begin
      cnt++;
      tick();
    end
    check("t5_req_cycles", 32'(cnt), 32'd2000);
    check("t5_timeout",    32'(o_timeout), 32'd1);
    check("t5_busy",       32'(o_busy), 32'd0);
    tick();
    check("t5_timeout_end", 32'(o_timeout), 32'd0);
    check("t5_sel_kept",    32'(sif.o_song_select), 32'd1);
    check("t5_sreq_low",    32'(sif.o_song_req), 32'd0);

    // T6: reset in VOL_REQ with a song also pending -> clean reset
    pulse(M_DEC);
    wait_req(1'b1, "t6");
    check("t6_level", 32'(o_vol_level), 32'd5);
    check("t6_vol",   32'(sif.o_vol),   32'h5050);
    check("t6_state", 32'(o_state_dbg), 32'(ST_VOL_REQ));
    pulse(M_NEXT);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset("t6r");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_no_sreq", 32'(sif.o_song_req), 32'd0);
      check("t6_no_vreq", 32'(sif.o_vol_req), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
